// File: rtl/yazmac_obegi_skorbord.sv
// yazmac_obegi_skorbord
//   Integer register file x0..x31 with a per-register pending-write
//   scoreboard. Decode reserves a destination at issue; writeback
//   writes data and releases one reservation.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   yazmaca_yaz_i         writeback write enable
//   hedef_yazmaci_i       writeback destination index
//   yazmac_veri_i         writeback data
//   kaynak1_i/kaynak2_i   read port indices
//   kaynakN_gecerli_i     decoded instruction uses source N
//   rezerve_et_i          decoded instruction issues and writes a register
//   rezerve_yazmac_i      destination to reserve
//   temizle_i             flush: clears every pending counter
//   kaynakN_veri_o        read data (write-through bypass from writeback)
//   kaynakN_mesgul_o      source N has an outstanding write
//   durdur_o              decode must hold; reservation not accepted
module yazmac_obegi_skorbord #(
   parameter int XLEN      = 32,
   parameter int SAYAC_BIT = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            yazmaca_yaz_i,
   input  logic [4:0]      hedef_yazmaci_i,
   input  logic [XLEN-1:0] yazmac_veri_i,
   input  logic [4:0]      kaynak1_i,
   input  logic [4:0]      kaynak2_i,
   input  logic            kaynak1_gecerli_i,
   input  logic            kaynak2_gecerli_i,
   input  logic            rezerve_et_i,
   input  logic [4:0]      rezerve_yazmac_i,
   input  logic            temizle_i,
   output logic [XLEN-1:0] kaynak1_veri_o,
   output logic [XLEN-1:0] kaynak2_veri_o,
   output logic            kaynak1_mesgul_o,
   output logic            kaynak2_mesgul_o,
   output logic            durdur_o
);

   localparam logic [SAYAC_BIT-1:0] SAYAC_MAX = '1;
   localparam logic [SAYAC_BIT-1:0] SAYAC_BIR = SAYAC_BIT'(1);

   logic [XLEN-1:0]      yazmac_q [32];
   logic [SAYAC_BIT-1:0] sayac_q  [32];
   logic [SAYAC_BIT-1:0] sayac_d  [32];

   logic yaz_gecerli;
   logic sayac_azalt;
   logic sayac_artir;
   logic rezerve_istek;
   logic doygun_durdur;
   logic azalt_k1, azalt_k2, azalt_rez;
   logic mesgul1, mesgul2;

   assign yaz_gecerli   = yazmaca_yaz_i & (hedef_yazmaci_i != 5'd0);
   assign sayac_azalt   = yaz_gecerli & (sayac_q[hedef_yazmaci_i] != '0);
   assign rezerve_istek = rezerve_et_i & (rezerve_yazmac_i != 5'd0);

   assign azalt_k1  = sayac_azalt & (hedef_yazmaci_i == kaynak1_i);
   assign azalt_k2  = sayac_azalt & (hedef_yazmaci_i == kaynak2_i);
   assign azalt_rez = sayac_azalt & (hedef_yazmaci_i == rezerve_yazmac_i);

   // A source whose last pending write lands this cycle is served by the
   // bypass, so only a count above one is busy in that case.
   assign mesgul1 = kaynak1_gecerli_i & (kaynak1_i != 5'd0) &
                    (azalt_k1 ? (sayac_q[kaynak1_i] > SAYAC_BIR) : (sayac_q[kaynak1_i] != '0));
   assign mesgul2 = kaynak2_gecerli_i & (kaynak2_i != 5'd0) &
                    (azalt_k2 ? (sayac_q[kaynak2_i] > SAYAC_BIR) : (sayac_q[kaynak2_i] != '0));

   // A saturated counter may still accept a reservation if a writeback
   // frees one slot on the same edge (inc and dec cancel).
   assign doygun_durdur = rezerve_istek & (sayac_q[rezerve_yazmac_i] == SAYAC_MAX) & ~azalt_rez;

   assign kaynak1_mesgul_o = ~rst_i & mesgul1;
   assign kaynak2_mesgul_o = ~rst_i & mesgul2;
   assign durdur_o         = ~rst_i & (mesgul1 | mesgul2 | doygun_durdur);
   assign sayac_artir      = rezerve_istek & ~durdur_o;

   always_comb begin
      kaynak1_veri_o = yazmac_q[kaynak1_i];
      kaynak2_veri_o = yazmac_q[kaynak2_i];
      if (yaz_gecerli && (hedef_yazmaci_i == kaynak1_i)) kaynak1_veri_o = yazmac_veri_i;
      if (yaz_gecerli && (hedef_yazmaci_i == kaynak2_i)) kaynak2_veri_o = yazmac_veri_i;
      // Bypass must not leak writeback data while reset is held.
      if (rst_i) begin
         kaynak1_veri_o = '0;
         kaynak2_veri_o = '0;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < 32; i++) begin
         sayac_d[i] = sayac_q[i];
         if (temizle_i) begin
            sayac_d[i] = '0;
         end else begin
            case ({sayac_artir && (rezerve_yazmac_i == 5'(i)),
                   sayac_azalt && (hedef_yazmaci_i == 5'(i))})
               2'b10:   sayac_d[i] = sayac_q[i] + SAYAC_BIR;
               2'b01:   sayac_d[i] = sayac_q[i] - SAYAC_BIR;
               default: sayac_d[i] = sayac_q[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < 32; i++) begin
            yazmac_q[i] <= '0;
            sayac_q[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 32; i++) begin
            sayac_q[i] <= sayac_d[i];
         end
         if (yaz_gecerli) yazmac_q[hedef_yazmaci_i] <= yazmac_veri_i;
      end
   end

endmodule
